// File: rtl/logic_gate_pkg.sv
// Shared definitions for the bitwise logic unit: op and state encodings plus
// the per-bit base-operation helpers used by the core and the top.
package logic_gate_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_ILL6 = 3'd6,
        OP_ILL7 = 3'd7
    } op_e;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

    // Inverting ops share their base with the plain ones; illegal codes yield 0.
    function automatic logic base_op(input logic [2:0] op, input logic x, input logic y);
        logic r;
        case (op)
            OP_AND, OP_NAND: r = x & y;
            OP_OR,  OP_NOR:  r = x | y;
            OP_XOR, OP_XNOR: r = x ^ y;
            default:         r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic op_inv(input logic [2:0] op);
        return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
    endfunction

    function automatic logic op_illegal(input logic [2:0] op);
        return (op == OP_ILL6) || (op == OP_ILL7);
    endfunction

endpackage

// File: rtl/logic_gate_core.sv
// Combinational slice: bitwise base op of two words, optional output inversion,
// and reduction of the (possibly inverted) result by the same base op.
module logic_gate_core
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    output logic [WIDTH-1:0] base_o,
    output logic [WIDTH-1:0] res_o,
    output logic             red_o
);

    // Bitwise base op, then inversion for the NAND/NOR/XNOR family.
    always_comb begin
        base_o = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            base_o[i] = base_op(op_i, x_i[i], y_i[i]);
        end
        if (op_inv(op_i)) begin
            res_o = ~base_o;
        end else begin
            res_o = base_o;
        end
    end

    // Reduction of the emitted word by the base op of the selected operation.
    always_comb begin
        case (op_i)
            OP_AND, OP_NAND: red_o = &res_o;
            OP_OR,  OP_NOR:  red_o = |res_o;
            OP_XOR, OP_XNOR: red_o = ^res_o;
            default:         red_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/logic_gate_unit.sv
// Registered two-operand bitwise logic unit with valid/ready handshakes and an
// optional accumulate mode that folds a multi-beat frame into one result.
module logic_gate_unit
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    input  logic             acc_mode,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] O,
    output logic             O_red,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             op_err
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e           state_q,     state_d;
    logic [2:0]       op_q,        op_d;
    logic [WIDTH-1:0] acc_q,       acc_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             err_q,       err_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] o_q,         o_d;
    logic             o_red_q,     o_red_d;
    logic [CNT_W-1:0] beat_cnt_q,  beat_cnt_d;
    logic             op_err_q,    op_err_d;

    logic [2:0]       eff_op_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             accept_s;
    logic [WIDTH-1:0] beat_base_s,  beat_res_s;
    logic [WIDTH-1:0] frame_base_s, frame_res_s;
    logic             beat_red_s,   frame_red_s;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept_s  = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign O         = o_q;
    assign O_red     = o_red_q;
    assign beat_cnt  = beat_cnt_q;
    assign op_err    = op_err_q;

    // Later beats of a frame follow the op latched on its first beat.
    always_comb begin
        if (state_q == ST_ACCUM) begin
            eff_op_s = op_q;
        end else begin
            eff_op_s = op;
        end
    end

    // Saturating beat count increment.
    always_comb begin
        if (cnt_q == CNT_MAX) begin
            cnt_inc_s = cnt_q;
        end else begin
            cnt_inc_s = cnt_q + CNT_ONE;
        end
    end

    // Operand path: b(A,B), plus the result a single-beat frame emits.
    logic_gate_core #(.WIDTH(WIDTH)) u_beat_core (
        .op_i   (eff_op_s),
        .x_i    (A),
        .y_i    (B),
        .base_o (beat_base_s),
        .res_o  (beat_res_s),
        .red_o  (beat_red_s)
    );

    // Accumulate path: b(acc, b(A,B)); inversion only ever reaches the output.
    logic_gate_core #(.WIDTH(WIDTH)) u_frame_core (
        .op_i   (eff_op_s),
        .x_i    (acc_q),
        .y_i    (beat_base_s),
        .base_o (frame_base_s),
        .res_o  (frame_res_s),
        .red_o  (frame_red_s)
    );

    // Next-state, accumulator and output-register update.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        o_d        = o_q;
        o_red_d    = o_red_q;
        beat_cnt_d = beat_cnt_q;
        op_err_d   = op_err_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (accept_s) begin
            case (state_q)
                ST_IDLE: begin
                    op_d  = op;
                    err_d = op_illegal(op);
                    acc_d = beat_base_s;
                    cnt_d = CNT_ONE;
                    if (acc_mode && !in_last) begin
                        state_d = ST_ACCUM;
                    end else begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b1;
                        o_d         = beat_res_s;
                        o_red_d     = beat_red_s;
                        beat_cnt_d  = CNT_ONE;
                        op_err_d    = op_illegal(op);
                    end
                end
                ST_ACCUM: begin
                    acc_d = frame_base_s;
                    cnt_d = cnt_inc_s;
                    if (in_last) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b1;
                        o_d         = frame_res_s;
                        o_red_d     = frame_red_s;
                        beat_cnt_d  = cnt_inc_s;
                        op_err_d    = err_q;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame context and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q        <= 3'd0;
            acc_q       <= {WIDTH{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            o_q         <= {WIDTH{1'b0}};
            o_red_q     <= 1'b0;
            beat_cnt_q  <= {CNT_W{1'b0}};
            op_err_q    <= 1'b0;
        end else begin
            op_q        <= op_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            o_q         <= o_d;
            o_red_q     <= o_red_d;
            beat_cnt_q  <= beat_cnt_d;
            op_err_q    <= op_err_d;
        end
    end

endmodule
